cpu_test_monitor: RTL and testbench
===================================

Name: cpu_test_monitor

Overview:
- Synthesizable, parametrised checker for the multicycle CPU's debug outputs (num_inst, output_port, is_halted).
- Holds a programmable table of checkpoints. Each checkpoint is an (instruction count, expected output_port) pair.
- Grades each checkpoint as the CPU runs, enforces a cycle budget, and reports pass/fail/skip counts plus details of the first failure.
- Sits beside the cpu top-level, so the same regression runs on FPGA and in simulation without a behavioural bench.

Parameters:
- WORD_SIZE, 16, width of num_inst, output_port, expected answers.
- NUM_TEST, 64, table capacity (checkpoints).
- IDX_W, 6, checkpoint index width; must satisfy 2**IDX_W >= NUM_TEST.
- CNT_W, 16, width of cycle and result counters.
- MAX_CYCLES, 10000, cycle budget per run.
- STOP_ON_FAIL, 1, 1 = end run on first failing checkpoint; 0 = continue.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe; honoured only in IDLE.
- cfg_idx  in  IDX_W  table entry index.
- cfg_inst  in  WORD_SIZE  checkpoint instruction count.
- cfg_ans  in  WORD_SIZE  expected output_port value.
- cfg_num  in  IDX_W+1  number of valid entries; latched on start.
- start  in  1  begin run; honoured only in IDLE.
- num_inst  in  WORD_SIZE  from cpu.
- output_port  in  WORD_SIZE  from cpu.
- is_halted  in  1  from cpu.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.
- all_pass  out  1  done & no fail & no skip & !timeout & pass_cnt==num_latched.
- timeout  out  1  run ended by cycle budget.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- pass_cnt, fail_cnt, skip_cnt  out  CNT_W each  checkpoint results.
- ff_valid  out  1  a failure was recorded.
- ff_idx  out  IDX_W  index of first failing entry.
- ff_got, ff_exp  out  WORD_SIZE each  observed and expected value at first failure.

Behaviour:
- Reset: state=IDLE. All outputs 0. ptr=0, matched=0, num_latched=0. Table contents are not reset.
- Table entries must be strictly ascending in cfg_inst. Ordering is not checked in hardware.
- IDLE:
  - cfg_we writes entry cfg_idx on the next edge. Writes with cfg_idx >= NUM_TEST are dropped.
  - start latches cfg_num, clears all counters and ff_*, and goes to RUN.
  - If cfg_num==0, start goes directly to DONE with all_pass=1.
- RUN, evaluated every cycle against entry tbl[ptr]:
  - If num_inst==tbl[ptr].inst: matched<=1 and cap<=output_port. The last value seen while the count matches is the graded value.
  - Else if matched: grade cap against tbl[ptr].ans. Increment pass_cnt or fail_cnt, then ptr++ and matched<=0. On the first fail, load ff_* (ff_got=cap).
  - Else if num_inst > tbl[ptr].inst (unsigned): checkpoint skipped. skip_cnt++ and ptr++.
  - cycle_cnt increments every RUN cycle and saturates.
- Run termination; state becomes DONE on the same edge as the triggering event, so done is visible next cycle:
  - ptr reaches num_latched after a grade or skip.
  - Fail when STOP_ON_FAIL=1.
  - is_halted=1. Any pending entry is graded in that cycle: if num_inst matches, use the live output_port; else if matched, use cap.
  - cycle_cnt==MAX_CYCLES-1 with no other terminator: set timeout=1.
- Priority when events coincide: halt > fail-stop > table exhausted > timeout. timeout is never set when halt occurs in the same cycle.
- Only one table entry is graded or skipped per cycle. Consecutive skipped entries each take one cycle.
- DONE: all result outputs hold. start re-arms a new run (same as IDLE start). cfg_we is ignored.
- reset asserted mid-RUN or in DONE: return to IDLE next edge and clear all outputs. Table is retained.
- Counter arithmetic is unsigned. Instruction comparisons are unsigned, WORD_SIZE wide.

Decomposition:
- Shared package cpu_test_pkg:
  - state enum IDLE/RUN/DONE.
  - result code enum PASS/FAIL/SKIP.
  - default MAX_CYCLES constant.
- Sub-module test_table: NUM_TEST x 2*WORD_SIZE register array. One synchronous write port, one asynchronous read port indexed by ptr. The FSM, counters and capture logic stay in cpu_test_monitor.

Test Plan:
- 3 entries {(3,0),(5,0),(7,2)}; drive num_inst 0..8, one step every 4 cycles, output_port=2 from num_inst 6 onward -> pass_cnt=3, all_pass=1, done rises one cycle after the num_inst 7->8 edge.
- Entry (11,1), output_port=5 while num_inst=11 -> fail_cnt=1, ff_idx=0, ff_got=5, ff_exp=1. With STOP_ON_FAIL=1, DONE on the grading edge.
- Entries {(4,0),(6,0)}; num_inst jumps 3->5 -> skip_cnt=1 for entry 0; entry 6 is then graded normally; all_pass=0.
- is_halted asserted while num_inst==0x3D5 matches the final entry (0x3D5,0x22), output_port=0x22 -> graded pass in the halt cycle, timeout=0.
- MAX_CYCLES=20, num_inst held at 0 -> timeout=1 after 20 RUN cycles, cycle_cnt=19. Same bench with is_halted also asserted on cycle 19 -> timeout=0.
- Assert reset mid-RUN, then issue start with the same table -> counters restart at 0 and the table is unchanged; a cfg_we pulse during RUN does not alter the table.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// Shared types and defaults for the CPU test monitor.
package cpu_test_pkg;

    // Monitor run state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Outcome of one checkpoint.
    typedef enum logic [1:0] {
        PASS = 2'd0,
        FAIL = 2'd1,
        SKIP = 2'd2
    } result_t;

    // Default cycle budget for one run.
    localparam int DEFAULT_MAX_CYCLES = 10000;

endpackage

// File: rtl/test_table.sv
// Checkpoint table: one synchronous write port and one asynchronous read port.
// Each entry packs {instruction count, expected output_port}.
module test_table #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_TEST  = 64,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [WORD_SIZE-1:0] i_wr_inst,
    input  logic [WORD_SIZE-1:0] i_wr_ans,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [WORD_SIZE-1:0] o_rd_inst,
    output logic [WORD_SIZE-1:0] o_rd_ans
);

    logic [2*WORD_SIZE-1:0] r_mem [NUM_TEST];
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic [2*WORD_SIZE-1:0] w_rd_word;

    // Writes aimed past the end of the table are dropped.
    assign w_wr_ok = i_we && (int'(i_wr_idx) < NUM_TEST);
    assign w_rd_ok = int'(i_rd_idx) < NUM_TEST;

    // Table write port.
    // NOTE: the array has no reset on purpose so it maps onto plain storage and
    // survives a monitor reset; sequential state is always assigned with <=.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_idx] <= {i_wr_inst, i_wr_ans};
        end
    end

    assign w_rd_word = w_rd_ok ? r_mem[i_rd_idx] : '0;
    assign o_rd_inst = w_rd_word[2*WORD_SIZE-1:WORD_SIZE];
    assign o_rd_ans  = w_rd_word[WORD_SIZE-1:0];

endmodule

// File: rtl/cpu_test_monitor.sv
// Checker for the multicycle CPU debug outputs: walks a checkpoint table,
// grades each (instruction count, output_port) pair, enforces a cycle budget
// and records the first failure.
module cpu_test_monitor
    import cpu_test_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int NUM_TEST     = 64,
    parameter int IDX_W        = 6,
    parameter int CNT_W        = 16,
    parameter int MAX_CYCLES   = DEFAULT_MAX_CYCLES,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [WORD_SIZE-1:0] cfg_inst,
    input  logic [WORD_SIZE-1:0] cfg_ans,
    input  logic [IDX_W:0]       cfg_num,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    output logic                 busy,
    output logic                 done,
    output logic                 all_pass,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     skip_cnt,
    output logic                 ff_valid,
    output logic [IDX_W-1:0]     ff_idx,
    output logic [WORD_SIZE-1:0] ff_got,
    output logic [WORD_SIZE-1:0] ff_exp
);

    localparam logic [CNT_W-1:0] LP_CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_ptr;
    logic                   r_matched;
    logic [WORD_SIZE-1:0]   r_cap;
    logic [IDX_W:0]         r_num_latched;
    logic [CNT_W-1:0]       r_cycle_cnt;
    logic [CNT_W-1:0]       r_pass_cnt;
    logic [CNT_W-1:0]       r_fail_cnt;
    logic [CNT_W-1:0]       r_skip_cnt;
    logic                   r_timeout;
    logic                   r_ff_valid;
    logic [IDX_W-1:0]       r_ff_idx;
    logic [WORD_SIZE-1:0]   r_ff_got;
    logic [WORD_SIZE-1:0]   r_ff_exp;

    logic [WORD_SIZE-1:0]   w_ent_inst;
    logic [WORD_SIZE-1:0]   w_ent_ans;
    logic                   w_tbl_we;
    logic                   w_hit;
    logic                   w_past;
    logic                   w_last;
    logic [IDX_W:0]         w_ptr_inc;
    logic                   w_clear;
    logic                   w_capture;
    logic                   w_grade;
    logic                   w_skip;
    logic                   w_timeout_set;
    logic                   w_cnt_inc;
    logic [WORD_SIZE-1:0]   w_grade_val;
    result_t                w_result;

    // The table only accepts writes while no run is active or finished.
    assign w_tbl_we = cfg_we && (r_state == IDLE);

    test_table #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_TEST  (NUM_TEST),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk       (clk),
        .i_we      (w_tbl_we),
        .i_wr_idx  (cfg_idx),
        .i_wr_inst (cfg_inst),
        .i_wr_ans  (cfg_ans),
        .i_rd_idx  (r_ptr),
        .o_rd_inst (w_ent_inst),
        .o_rd_ans  (w_ent_ans)
    );

    assign w_hit     = (num_inst == w_ent_inst);
    assign w_past    = (num_inst > w_ent_inst);
    assign w_ptr_inc = {1'b0, r_ptr} + (IDX_W+1)'(1);
    assign w_last    = (w_ptr_inc == r_num_latched);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle actions; halt outranks fail-stop, which
    // outranks table exhaustion, which outranks the cycle budget.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_clear       = 1'b0;
        w_capture     = 1'b0;
        w_grade       = 1'b0;
        w_skip        = 1'b0;
        w_timeout_set = 1'b0;
        w_cnt_inc     = 1'b0;
        w_grade_val   = r_cap;
        w_result      = PASS;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = (cfg_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (is_halted) begin
                    w_state_nxt = DONE;
                    if (w_hit) begin
                        w_grade     = 1'b1;
                        w_grade_val = output_port;
                    end else if (r_matched) begin
                        w_grade = 1'b1;
                    end
                end else if (w_hit) begin
                    w_capture = 1'b1;
                end else if (r_matched) begin
                    w_grade = 1'b1;
                    if (STOP_ON_FAIL && (r_cap != w_ent_ans)) begin
                        w_state_nxt = DONE;
                    end else if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end else if (w_past) begin
                    w_skip = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                // The budget only ends the run when nothing else already did;
                // the terminating cycle itself is not counted.
                if (w_state_nxt == RUN) begin
                    if (r_cycle_cnt == LP_CYC_LAST) begin
                        w_timeout_set = 1'b1;
                        w_state_nxt   = DONE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_skip) begin
            w_result = SKIP;
        end else if (w_grade_val != w_ent_ans) begin
            w_result = FAIL;
        end
    end

    // Run datapath: pointer, capture, counters and first-failure record.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_matched     <= 1'b0;
            r_cap         <= '0;
            r_num_latched <= '0;
            r_cycle_cnt   <= '0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_skip_cnt    <= '0;
            r_timeout     <= 1'b0;
            r_ff_valid    <= 1'b0;
            r_ff_idx      <= '0;
            r_ff_got      <= '0;
            r_ff_exp      <= '0;
        end else if (w_clear) begin
            r_ptr         <= '0;
            r_matched     <= 1'b0;
            r_cap         <= '0;
            r_num_latched <= cfg_num;
            r_cycle_cnt   <= '0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_skip_cnt    <= '0;
            r_timeout     <= 1'b0;
            r_ff_valid    <= 1'b0;
            r_ff_idx      <= '0;
            r_ff_got      <= '0;
            r_ff_exp      <= '0;
        end else begin
            if (w_capture) begin
                r_matched <= 1'b1;
                r_cap     <= output_port;
            end
            if (w_grade) begin
                r_ptr     <= r_ptr + IDX_W'(1);
                r_matched <= 1'b0;
                if (w_result == PASS) begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end else begin
                    r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    if (!r_ff_valid) begin
                        r_ff_valid <= 1'b1;
                        r_ff_idx   <= r_ptr;
                        r_ff_got   <= w_grade_val;
                        r_ff_exp   <= w_ent_ans;
                    end
                end
            end
            if (w_skip) begin
                r_ptr      <= r_ptr + IDX_W'(1);
                r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            end
            if (w_cnt_inc && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign all_pass  = done && (r_fail_cnt == '0) && (r_skip_cnt == '0) && !r_timeout
                       && (r_pass_cnt == CNT_W'(r_num_latched));
    assign timeout   = r_timeout;
    assign cycle_cnt = r_cycle_cnt;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign skip_cnt  = r_skip_cnt;
    assign ff_valid  = r_ff_valid;
    assign ff_idx    = r_ff_idx;
    assign ff_got    = r_ff_got;
    assign ff_exp    = r_ff_exp;

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed bench for cpu_test_monitor: default instance plus a short-budget
// instance sharing the same stimulus.
module tb_cpu_test_monitor;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [5:0]  cfg_idx;
    logic [15:0] cfg_inst;
    logic [15:0] cfg_ans;
    logic [6:0]  cfg_num;
    logic        start;
    logic [15:0] num_inst;
    logic [15:0] output_port;
    logic        is_halted;

    logic        busy, done, all_pass, timeout, ff_valid;
    logic [15:0] cycle_cnt, pass_cnt, fail_cnt, skip_cnt, ff_got, ff_exp;
    logic [5:0]  ff_idx;

    logic        busy_t, done_t, all_pass_t, timeout_t, ff_valid_t;
    logic [15:0] cycle_cnt_t, pass_cnt_t, fail_cnt_t, skip_cnt_t, ff_got_t, ff_exp_t;
    logic [5:0]  ff_idx_t;

    int n_checks = 0;
    int n_errors = 0;

    cpu_test_monitor u_dut (
        .clk (clk), .reset (reset), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
        .cfg_inst (cfg_inst), .cfg_ans (cfg_ans), .cfg_num (cfg_num), .start (start),
        .num_inst (num_inst), .output_port (output_port), .is_halted (is_halted),
        .busy (busy), .done (done), .all_pass (all_pass), .timeout (timeout),
        .cycle_cnt (cycle_cnt), .pass_cnt (pass_cnt), .fail_cnt (fail_cnt),
        .skip_cnt (skip_cnt), .ff_valid (ff_valid), .ff_idx (ff_idx),
        .ff_got (ff_got), .ff_exp (ff_exp)
    );

    cpu_test_monitor #(.MAX_CYCLES(20)) u_dut_to (
        .clk (clk), .reset (reset), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
        .cfg_inst (cfg_inst), .cfg_ans (cfg_ans), .cfg_num (cfg_num), .start (start),
        .num_inst (num_inst), .output_port (output_port), .is_halted (is_halted),
        .busy (busy_t), .done (done_t), .all_pass (all_pass_t), .timeout (timeout_t),
        .cycle_cnt (cycle_cnt_t), .pass_cnt (pass_cnt_t), .fail_cnt (fail_cnt_t),
        .skip_cnt (skip_cnt_t), .ff_valid (ff_valid_t), .ff_idx (ff_idx_t),
        .ff_got (ff_got_t), .ff_exp (ff_exp_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [5:0] idx, input logic [15:0] inst, input logic [15:0] ans);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_inst = inst;
        cfg_ans  = ans;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic start_run(input logic [6:0] num);
        cfg_num = num;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic drive(input logic [15:0] n, input logic [15:0] op);
        num_inst    = n;
        output_port = op;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check(tag, done, 1);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_inst = '0; cfg_ans = '0;
        cfg_num = '0; start = 1'b0; num_inst = '0; output_port = '0; is_halted = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_all_pass", all_pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_counts", {pass_cnt, fail_cnt}, 0);
        check("rst_skip_cyc", {skip_cnt, cycle_cnt}, 0);
        check("rst_ff", {ff_valid, ff_idx, ff_got}, 0);

        // Empty table: straight to DONE with all_pass.
        start_run(7'd0);
        check("empty_done", done, 1);
        check("empty_all_pass", all_pass, 1);

        // Three passing checkpoints, num_inst stepping every 4 cycles.
        do_reset();
        wr(6'd0, 16'd3, 16'd0);
        wr(6'd1, 16'd5, 16'd0);
        wr(6'd2, 16'd7, 16'd2);
        start_run(7'd3);
        check("t1_busy", busy, 1);
        for (int n = 0; n < 8; n++) begin
            drive(16'(n), (n >= 6) ? 16'd2 : 16'd0);
            repeat (4) tick();
        end
        drive(16'd8, 16'd2);
        check("t1_not_done_yet", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_pass_cnt", pass_cnt, 3);
        check("t1_all_pass", all_pass, 1);
        check("t1_fail_skip", {fail_cnt, skip_cnt}, 0);
        check("t1_cycle_cnt", cycle_cnt, 32);

        // Failing first checkpoint stops the run on the grading edge.
        do_reset();
        drive(16'd0, 16'd0);
        wr(6'd0, 16'd11, 16'd1);
        wr(6'd1, 16'd13, 16'd3);
        start_run(7'd2);
        drive(16'd11, 16'd5);
        tick();
        tick();
        drive(16'd12, 16'd0);
        check("t2_not_done_yet", done, 0);
        tick();
        check("t2_done", done, 1);
        check("t2_fail_cnt", fail_cnt, 1);
        check("t2_pass_cnt", pass_cnt, 0);
        check("t2_ff_valid", ff_valid, 1);
        check("t2_ff_idx", ff_idx, 0);
        check("t2_ff_got", ff_got, 5);
        check("t2_ff_exp", ff_exp, 1);
        check("t2_all_pass", all_pass, 0);

        // Writes in DONE are ignored; start re-arms from DONE.
        wr(6'd0, 16'd11, 16'd5);
        drive(16'd0, 16'd0);
        start_run(7'd2);
        check("t2r_busy", busy, 1);
        check("t2r_cleared", {fail_cnt, 15'd0, ff_valid}, 0);
        drive(16'd11, 16'd5);
        tick();
        drive(16'd12, 16'd0);
        tick();
        check("t2r_fail_cnt", fail_cnt, 1);
        check("t2r_ff_exp", ff_exp, 1);

        // Skipped checkpoint followed by a normal grade.
        do_reset();
        drive(16'd0, 16'd0);
        wr(6'd0, 16'd4, 16'd0);
        wr(6'd1, 16'd6, 16'd0);
        start_run(7'd2);
        drive(16'd3, 16'd0);
        tick();
        drive(16'd5, 16'd0);
        tick();
        check("t3_skip_cnt", skip_cnt, 1);
        drive(16'd6, 16'd0);
        tick();
        drive(16'd7, 16'd0);
        wait_done("t3_done", 10);
        check("t3_pass_cnt", pass_cnt, 1);
        check("t3_skip_final", skip_cnt, 1);
        check("t3_all_pass", all_pass, 0);

        // Halt while the final checkpoint matches: graded with live output_port.
        do_reset();
        drive(16'd0, 16'd0);
        wr(6'd0, 16'h0100, 16'h0011);
        wr(6'd1, 16'h03D5, 16'h0022);
        start_run(7'd2);
        drive(16'h0100, 16'h0011);
        tick();
        drive(16'h0101, 16'h0000);
        tick();
        drive(16'h03D5, 16'h0022);
        is_halted = 1'b1;
        tick();
        is_halted = 1'b0;
        check("t4_done", done, 1);
        check("t4_pass_cnt", pass_cnt, 2);
        check("t4_timeout", timeout, 0);
        check("t4_all_pass", all_pass, 1);

        // Cycle budget of 20 on the short-budget instance.
        do_reset();
        drive(16'd0, 16'd0);
        wr(6'd0, 16'd5, 16'd0);
        start_run(7'd1);
        repeat (19) tick();
        check("t5_busy_19", busy_t, 1);
        check("t5_no_timeout_19", timeout_t, 0);
        tick();
        check("t5_done", done_t, 1);
        check("t5_timeout", timeout_t, 1);
        check("t5_cycle_cnt", cycle_cnt_t, 19);
        check("t5_all_pass", all_pass_t, 0);

        // Same budget, but halt lands on the last budgeted cycle.
        do_reset();
        start_run(7'd1);
        repeat (19) tick();
        is_halted = 1'b1;
        tick();
        is_halted = 1'b0;
        check("t5h_done", done_t, 1);
        check("t5h_timeout", timeout_t, 0);
        check("t5h_cycle_cnt", cycle_cnt_t, 19);

        // Reset mid-run, write attempt during RUN, then a clean restart.
        do_reset();
        wr(6'd0, 16'd3, 16'd0);
        wr(6'd1, 16'd5, 16'd0);
        wr(6'd2, 16'd7, 16'd2);
        start_run(7'd3);
        drive(16'd3, 16'd0);
        tick();
        drive(16'd4, 16'd0);
        tick();
        check("t6_pass_before", pass_cnt, 1);
        wr(6'd0, 16'd3, 16'd9);
        do_reset();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pass", pass_cnt, 0);
        check("t6_rst_cycle", cycle_cnt, 0);
        drive(16'd0, 16'd0);
        start_run(7'd3);
        check("t6_restart_cycle", cycle_cnt, 0);
        check("t6_restart_busy", busy, 1);
        drive(16'd3, 16'd0);
        tick();
        drive(16'd4, 16'd0);
        tick();
        check("t6_table_kept_pass", pass_cnt, 1);
        check("t6_table_kept_fail", fail_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
